// File: rtl/led_seq_pkg.sv
// Shared encodings for the LED pattern sequencer: modes, register map, STATUS layout.
package led_seq_pkg;

    typedef enum logic [2:0] {
        ModeStatic = 3'd0,
        ModeBlink  = 3'd1,
        ModeRotate = 3'd2,
        ModeBounce = 3'd3,
        ModeCount  = 3'd4
    } mode_e;

    localparam logic [1:0] AddrCtrl    = 2'd0;
    localparam logic [1:0] AddrPattern = 2'd1;
    localparam logic [1:0] AddrPeriod  = 2'd2;
    localparam logic [1:0] AddrStatus  = 2'd3;

    localparam int unsigned PeriodRst = 12500000;

    localparam int unsigned StatusRunningBit = 9;
    localparam int unsigned StatusDirBit     = 10;
    localparam int unsigned StatusStepsLsb   = 16;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Avalon-MM slave bus of the LED pattern sequencer.
interface led_pattern_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/led_seq_prescaler.sv
// Step-period prescaler: one-cycle tick every PERIOD clocks while running.
module led_seq_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        clear,
    input  logic [23:0] period,
    output logic        tick
);
    logic [23:0] count_q;
    logic [23:0] last;

    // A period of zero steps every clock, same as one.
    assign last = (period == 24'd0) ? 24'd0 : period - 24'd1;
    assign tick = run && !clear && (count_q >= last);

    always_ff @(posedge clk) begin
        if (reset || clear || !run) begin
            count_q <= 24'd0;
        end else if (count_q >= last) begin
            count_q <= 24'd0;
        end else begin
            count_q <= count_q + 24'd1;
        end
    end
endmodule

// File: rtl/led_pattern_sequencer.sv
// Avalon-MM LED sequencer: register file, pattern stepping logic and read mux.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned WIDTH      = 9,
    parameter int unsigned PERIOD_RST = PeriodRst
) (
    input  logic                 clk,
    input  logic                 reset,
    led_pattern_sequencer_if.slave bus,
    output logic [WIDTH-1:0]     out_port
);
    logic             en_q;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] pattern_q;
    logic [23:0]      period_q;
    logic [WIDTH-1:0] work_q;
    logic             dir_q;
    logic [15:0]      steps_q;

    logic             wr, wr_ctrl, wr_pattern, wr_period;
    logic             reload, is_static, running, tick;
    logic [WIDTH-1:0] reload_pattern, work_step;
    logic             dir_step;
    logic [31:0]      status, rdata;
    logic             unused_wdata;

    assign wr         = bus.chipselect && !bus.write_n;
    assign wr_ctrl    = wr && (bus.address == AddrCtrl);
    assign wr_pattern = wr && (bus.address == AddrPattern);
    assign wr_period  = wr && (bus.address == AddrPeriod);
    assign reload     = wr_ctrl || wr_pattern;
    assign unused_wdata = ^bus.writedata[31:24];

    // Reserved codes 5..7 behave exactly like STATIC.
    assign is_static = (mode_q == ModeStatic) || (mode_q > ModeCount);
    assign running   = en_q && !is_static;
    assign reload_pattern = wr_pattern ? bus.writedata[WIDTH-1:0] : pattern_q;

    led_seq_prescaler u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .run    (running),
        .clear  (reload || wr_period),
        .period (period_q),
        .tick   (tick)
    );

    always_comb begin
        work_step = work_q;
        dir_step  = dir_q;
        case (mode_q)
            ModeBlink:  work_step = work_q ^ pattern_q;
            ModeRotate: work_step = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            ModeBounce: begin
                if (!dir_q && work_q[WIDTH-1]) begin
                    dir_step  = 1'b1;
                    work_step = work_q >> 1;
                end else if (dir_q && work_q[0]) begin
                    dir_step  = 1'b0;
                    work_step = work_q << 1;
                end else if (dir_q) begin
                    work_step = work_q >> 1;
                end else begin
                    work_step = work_q << 1;
                end
            end
            ModeCount:  work_step = work_q + WIDTH'(1);
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q      <= 1'b0;
            mode_q    <= 3'd0;
            pattern_q <= '0;
            period_q  <= 24'(PERIOD_RST);
            work_q    <= '0;
            dir_q     <= 1'b0;
            steps_q   <= 16'd0;
        end else begin
            if (wr_ctrl)    {mode_q, en_q} <= bus.writedata[3:0];
            if (wr_pattern) pattern_q <= bus.writedata[WIDTH-1:0];
            if (wr_period)  period_q <= bus.writedata[23:0];
            // A bus write always beats a coincident tick.
            if (reload) begin
                work_q  <= reload_pattern;
                dir_q   <= 1'b0;
                steps_q <= 16'd0;
            end else if (is_static) begin
                work_q <= pattern_q;
            end else if (tick) begin
                work_q  <= work_step;
                dir_q   <= dir_step;
                steps_q <= steps_q + 16'd1;
            end
        end
    end

    always_comb begin
        status = '0;
        status[WIDTH-1:0]              = work_q;
        status[StatusRunningBit]       = running;
        status[StatusDirBit]           = dir_q;
        status[StatusStepsLsb +: 16]   = steps_q;
        case (bus.address)
            AddrCtrl:    rdata = {28'd0, mode_q, en_q};
            AddrPattern: rdata = 32'(pattern_q);
            AddrPeriod:  rdata = {8'd0, period_q};
            default:     rdata = status;
        endcase
    end

    assign bus.readdata = rdata;
    assign out_port     = work_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench: stimulus queues expected LED steps and reads, a negedge monitor checks them.
module tb_led_pattern_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] out_port;

    led_pattern_sequencer_if bus ();

    led_pattern_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] val;
        int         at;
    } led_exp_t;

    typedef struct {
        string       name;
        bit          is_led;
        logic [31:0] val;
    } probe_t;

    led_exp_t   exp_led[$];
    probe_t     exp_probe[$];
    bit         armed = 1'b0;
    bit         rd_req = 1'b0;
    bit         done = 1'b0;
    logic [8:0] prev_led;
    int         n_vec = 0;
    int         n_bad = 0;
    int         wr_edge = 0;

    // Monitor: every LED change pops one expected step; every read request pops one probe.
    always @(negedge clk) begin
        led_exp_t    e;
        probe_t      p;
        logic [31:0] got;
        if (!armed) begin
            prev_led = out_port;
        end else if (out_port !== prev_led) begin
            n_vec++;
            if (exp_led.size() == 0) begin
                n_bad++;
                $display("FAIL led_unexpected: got %h at cycle %0d, expected no change", out_port, cyc);
            end else begin
                e = exp_led.pop_front();
                if (out_port !== e.val || (e.at >= 0 && e.at != cyc)) begin
                    n_bad++;
                    $display("FAIL led_step: got %h at cycle %0d, expected %h at cycle %0d",
                             out_port, cyc, e.val, e.at);
                end
            end
            prev_led = out_port;
        end
        if (rd_req) begin
            n_vec++;
            if (exp_probe.size() == 0) begin
                n_bad++;
                $display("FAIL probe_underflow: read with no expectation at cycle %0d", cyc);
            end else begin
                p = exp_probe.pop_front();
                got = p.is_led ? {23'd0, out_port} : bus.readdata;
                if (got !== p.val) begin
                    n_bad++;
                    $display("FAIL %s: got %h, expected %h", p.name, got, p.val);
                end
            end
        end
        if (done) begin
            n_vec++;
            if (exp_led.size() != 0 || exp_probe.size() != 0) begin
                n_bad++;
                $display("FAIL leftover: %0d LED steps and %0d reads unobserved, expected 0",
                         exp_led.size(), exp_probe.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
            $finish;
        end
        if (cyc > 20000) begin
            $display("FAIL watchdog: reached cycle %0d, expected finish before 20000", cyc);
            $fatal(1, "timeout");
        end
    end

    task automatic push_led(input logic [8:0] v, input int at);
        exp_led.push_back('{val: v, at: at});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        wr_edge        = cyc;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write so that the strobe is sampled on clock edge e.
    task automatic wr_at(input int e, input logic [1:0] a, input logic [31:0] d);
        wait_cyc(e - 1);
        wr(a, d);
    endtask

    task automatic probe(input string nm, input bit is_led, input logic [1:0] a,
                         input logic [31:0] v);
        bus.address = a;
        exp_probe.push_back('{name: nm, is_led: is_led, val: v});
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    logic [8:0] rot_tab[9] = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h080,
                               9'h100, 9'h001};
    logic [8:0] bnc_tab[19] = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040, 9'h080,
                                9'h100, 9'h080, 9'h040, 9'h020, 9'h010, 9'h008, 9'h004,
                                9'h002, 9'h001, 9'h002, 9'h004, 9'h001};

    initial begin
        int w;
        int p;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        armed = 1'b1;

        probe("rst_ctrl", 1'b0, 2'd0, 32'd0);
        probe("rst_pattern", 1'b0, 2'd1, 32'd0);
        probe("rst_period", 1'b0, 2'd2, 32'd12500000);
        probe("rst_status", 1'b0, 2'd3, 32'd0);
        probe("rst_out_port", 1'b1, 2'd0, 32'd0);

        // ROTATE, PERIOD 4
        wr(2'd2, 32'd4);
        push_led(9'h001, -1);
        wr(2'd1, 32'h001);
        wr(2'd0, 32'h5);
        w = wr_edge;
        for (int k = 1; k <= 9; k++) push_led(rot_tab[k-1], w + 4 * k);
        wait_cyc(w + 8);
        probe("rotate_status", 1'b0, 2'd3, 32'h0002_0204);
        wait_cyc(w + 36);
        // PATTERN write landing on the tick edge
        push_led(9'h0F0, w + 40);
        wr_at(w + 40, 2'd1, 32'h0F0);
        probe("coincident_status", 1'b0, 2'd3, 32'h0000_02F0);
        push_led(9'h1E0, w + 44);
        wait_cyc(w + 44);
        // PERIOD 0 steps every clock
        wr(2'd2, 32'd0);
        p = wr_edge;
        push_led(9'h1C1, p + 1);
        push_led(9'h183, p + 2);
        push_led(9'h107, p + 3);
        push_led(9'h0F0, p + 4);
        wr_at(p + 4, 2'd0, 32'h4);

        // BOUNCE, PERIOD 1
        wr(2'd2, 32'd1);
        push_led(9'h001, -1);
        wr(2'd1, 32'h001);
        wr(2'd0, 32'h7);
        w = wr_edge;
        for (int k = 1; k <= 19; k++) push_led(bnc_tab[k-1], w + k);
        wait_cyc(w + 9);
        probe("bounce_dir_right", 1'b0, 2'd3, 32'h0009_0680);
        wait_cyc(w + 17);
        probe("bounce_dir_left", 1'b0, 2'd3, 32'h0011_0202);
        wr_at(w + 19, 2'd0, 32'h6);

        // BLINK, PERIOD 2, then freeze
        wr(2'd2, 32'd2);
        push_led(9'h155, -1);
        wr(2'd1, 32'h155);
        wr(2'd0, 32'h3);
        w = wr_edge;
        push_led(9'h000, w + 2);
        push_led(9'h155, w + 4);
        push_led(9'h000, w + 6);
        push_led(9'h155, w + 7);
        wr_at(w + 7, 2'd0, 32'h2);
        wait_cyc(cyc + 12);
        probe("blink_frozen_status", 1'b0, 2'd3, 32'h0000_0155);
        probe("blink_frozen_ctrl", 1'b0, 2'd0, 32'h0000_0002);

        // COUNT wraps from 0x1FF, then reset mid-sequence
        push_led(9'h1FF, -1);
        wr(2'd1, 32'h1FF);
        wr(2'd0, 32'h9);
        w = wr_edge;
        push_led(9'h000, w + 2);
        push_led(9'h001, w + 4);
        push_led(9'h002, w + 6);
        wait_cyc(w + 6);
        push_led(9'h000, w + 7);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        probe("reset_ctrl", 1'b0, 2'd0, 32'd0);
        probe("reset_pattern", 1'b0, 2'd1, 32'd0);
        probe("reset_period", 1'b0, 2'd2, 32'd12500000);
        wait_cyc(cyc + 20);
        probe("reset_status", 1'b0, 2'd3, 32'd0);
        probe("reset_out_port", 1'b1, 2'd0, 32'd0);
        done = 1'b1;
    end
endmodule
